uart_hid_injector: RTL and testbench
====================================

Name: uart_hid_injector

Overview:
- Receives framed HID reports over UART and presents them on the same report interface the HID printer and other HID consumers use.
- Outputs are usb_type, a one-cycle usb_report strobe, and the keyboard, mouse and gamepad fields.
- A host PC or test script can inject keyboard, mouse and gamepad activity without a physical USB device.
- Contains a UART receiver (8N1, LSB first) and a frame-parser state machine with XOR checksum and inter-byte timeout.

Parameters:
- CLK_FREQ, 12000000, system clock in Hz.
- BAUD, 115200, UART bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (104 at the defaults), integer clocks per bit.
- TIMEOUT_CYCLES, 120000, maximum idle clocks between bytes inside a frame (10 ms).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial input, asynchronous to clk, idles high.
- usb_type  out  2  0=none, 1=keyboard, 2=mouse, 3=gamepad; type of the last accepted frame.
- usb_report  out  1  one-cycle strobe: a new report is valid on the outputs.
- key_modifiers  out  8  keyboard modifier byte.
- key1, key2, key3, key4  out  8 each  keyboard scancodes.
- mouse_btn  out  8  mouse buttons.
- mouse_dx, mouse_dy  out  8 signed  mouse deltas, two's complement.
- game_l, game_r, game_u, game_d, game_a, game_b, game_x, game_y, game_sel, game_sta  out  1 each  gamepad buttons.
- frame_err  out  1  one-cycle strobe: frame discarded.

Behaviour:
- Reset:
  - Async on resetn low; all outputs go to 0.
  - The uart_rx 2-flop synchroniser resets to 1.
  - Parser goes to IDLE; the RX FSM goes to R_IDLE.
- UART RX FSM (states R_IDLE, R_START, R_DATA, R_STOP):
  - R_IDLE: a synchronised 1->0 transition moves to R_START.
  - R_START: wait CLKS_PER_BIT/2 clocks, then resample. If the line is high, it was a glitch: return to R_IDLE. If low, go to R_DATA.
  - R_DATA: sample 8 bits, each CLKS_PER_BIT clocks apart, LSB first.
  - R_STOP: sample after CLKS_PER_BIT clocks. If 1, raise an internal byte_valid for one cycle with the byte. If 0 (framing error), drop the byte, force the parser to IDLE and pulse frame_err if the parser was not in IDLE.
  - Then return to R_IDLE. The next start bit is accepted from the cycle after the stop-bit sample.
- Frame format: 0xA5, TYPE, PAYLOAD..., CHK, where CHK = XOR of TYPE and all payload bytes.
  - TYPE 1 payload (5 bytes): modifiers, key1, key2, key3, key4.
  - TYPE 2 payload (3 bytes): btn, dx, dy.
  - TYPE 3 payload (2 bytes):
    - byte0 = {l, r, u, d, a, b, x, y}, MSB first.
    - byte1 = {6'b0, sel, sta}; the upper 6 bits are ignored.
- Parser FSM (states IDLE, TYPE, PAYLOAD, CHECK):
  - IDLE: 0xA5 goes to TYPE. Any other byte is ignored silently.
  - TYPE: a value of 1..3 latches the type, loads the payload length (5/3/2) and goes to PAYLOAD. A value of 0 or >3 pulses frame_err and goes to IDLE.
  - PAYLOAD: bytes go into a 5-byte shadow buffer; the running XOR is updated. After the last byte, go to CHECK.
  - CHECK:
    - Match: the cycle after byte_valid, copy the shadow buffer into the outputs of that type, set usb_type and pulse usb_report, all on the same edge. Outputs of other types keep their values.
    - Mismatch: pulse frame_err; outputs are unchanged.
    - Either way, go to IDLE.
- 0xA5 inside a frame is data. There is no resync; only timeout or a framing error recovers.
- Timeout: outside IDLE, a counter clears on each byte_valid. At TIMEOUT_CYCLES, pulse frame_err and go to IDLE.
- usb_report and frame_err are never high in the same cycle. Each is high for exactly one cycle per event.
- Output fields are stable between usb_report strobes.
- Back-to-back frames with no idle gap are supported.

Test Plan:
- Keyboard: send A5 01 02 04 00 00 00 07 -> exactly one usb_report pulse; usb_type=1, key_modifiers=02, key1=04, key2..4=00; frame_err stays 0.
- Mouse: send A5 02 01 05 FB FD -> usb_report; usb_type=2, mouse_btn=01, mouse_dx=+5, mouse_dy=-5. The keyboard fields still hold their previous values.
- Gamepad: send A5 03 88 01 8A -> usb_report; game_l=1, game_a=1, game_sta=1, all other buttons 0, usb_type=3. Then send the same frame with CHK=8B -> frame_err pulse, no usb_report, outputs unchanged.
- Robustness, three cases:
  - Bad type: A5 07 -> frame_err, parser back in IDLE.
  - Junk: send 00 FF, then a valid mouse frame -> the junk is ignored and the mouse report arrives.
  - Stop bit: corrupt the stop bit (0) on the dx byte -> frame_err, no report.
- Timeout: send A5 01 02, then idle 120000+ clocks -> one frame_err. A following valid keyboard frame is then accepted.
- Reset: assert resetn low mid-payload for 3 clocks -> all outputs 0 immediately. A subsequent complete valid frame produces a correct report. Separately, a 20-clock low glitch on uart_rx produces no byte.

Source files
------------

// File: rtl/uart_hid_injector.sv
// uart_hid_injector
//   Receives framed HID reports over an 8N1 UART line and republishes them on
//   the report interface used by the HID consumers.
//   Frame: 0xA5, TYPE, PAYLOAD..., CHK. CHK is the XOR of TYPE and the payload.
//   TYPE 1 = keyboard (5 bytes), 2 = mouse (3 bytes), 3 = gamepad (2 bytes).
//
// Ports
//   clk, resetn        system clock, asynchronous active-low reset
//   uart_rx            serial input, asynchronous to clk, idles high
//   usb_type           type of the last accepted frame (0 = none)
//   usb_report         one-cycle strobe: new report on the outputs
//   key_*/mouse_*/game_* report fields; each group only changes when a frame
//                      of its own type is accepted
//   frame_err          one-cycle strobe: a frame was discarded
//
// Internal byte stream: byte_valid is a single-cycle strobe that qualifies
// rx_shift. There is no ready/back-pressure; the parser consumes every byte
// in the cycle it is offered.
module uart_hid_injector #(
    parameter int CLK_FREQ       = 12000000,
    parameter int BAUD           = 115200,
    parameter int CLKS_PER_BIT   = CLK_FREQ / BAUD,
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              uart_rx,
    output logic [1:0]        usb_type,
    output logic              usb_report,
    output logic [7:0]        key_modifiers,
    output logic [7:0]        key1,
    output logic [7:0]        key2,
    output logic [7:0]        key3,
    output logic [7:0]        key4,
    output logic [7:0]        mouse_btn,
    output logic signed [7:0] mouse_dx,
    output logic signed [7:0] mouse_dy,
    output logic              game_l,
    output logic              game_r,
    output logic              game_u,
    output logic              game_d,
    output logic              game_a,
    output logic              game_b,
    output logic              game_x,
    output logic              game_y,
    output logic              game_sel,
    output logic              game_sta,
    output logic              frame_err
);

    localparam int BIT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BIT_W-1:0] FULL_LAST = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(CLKS_PER_BIT / 2 - 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    // ---------------- input synchroniser + edge history ----------------
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ---------------- UART receiver FSM ----------------
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    rx_state_t rx_state, rx_next;

    logic [BIT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             half_done, full_done;
    logic             byte_valid, stop_err;

    assign half_done = (bit_cnt == HALF_LAST);
    assign full_done = (bit_cnt == FULL_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rx_state <= R_IDLE;
        else         rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            // Edge rather than level: after a framing error the line may
            // still be low, and that must not look like a new start bit.
            R_IDLE:  if (rx_prev && !rx_sync) rx_next = R_START;
            R_START: if (half_done) rx_next = rx_sync ? R_IDLE : R_DATA;
            R_DATA:  if (full_done && bit_idx == 3'd7) rx_next = R_STOP;
            R_STOP:  if (full_done) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = (rx_state == R_STOP) && full_done &&  rx_sync;
        stop_err   = (rx_state == R_STOP) && full_done && !rx_sync;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                R_START: begin
                    bit_cnt <= half_done ? '0 : bit_cnt + 1'b1;
                    bit_idx <= '0;
                end
                R_DATA: begin
                    bit_cnt <= full_done ? '0 : bit_cnt + 1'b1;
                    if (full_done) begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};  // LSB first
                        bit_idx  <= bit_idx + 1'b1;
                    end
                end
                R_STOP:  bit_cnt <= full_done ? '0 : bit_cnt + 1'b1;
                default: bit_cnt <= '0;
            endcase
        end
    end

    // ---------------- frame parser FSM ----------------
    typedef enum logic [1:0] {IDLE, TYPE, PAYLOAD, CHECK} p_state_t;
    p_state_t p_state, p_next;

    logic [1:0]       ftype;
    logic [2:0]       pay_len, pay_idx;
    logic [7:0]       chk;
    logic [4:0][7:0]  shadow;
    logic [TMO_W-1:0] tmo_cnt;
    logic             type_ok, tmo_hit, chk_ok;
    logic             report_now, err_now;

    assign type_ok = (rx_shift == 8'd1) || (rx_shift == 8'd2) || (rx_shift == 8'd3);
    assign chk_ok  = (rx_shift == chk);
    // A byte arriving in the same cycle wins over an expiring timeout.
    assign tmo_hit = (p_state != IDLE) && !byte_valid && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) p_state <= IDLE;
        else         p_state <= p_next;
    end

    always_comb begin
        p_next = p_state;
        if (stop_err || tmo_hit) begin
            p_next = IDLE;
        end else if (byte_valid) begin
            case (p_state)
                IDLE:    if (rx_shift == 8'hA5) p_next = TYPE;
                TYPE:    p_next = type_ok ? PAYLOAD : IDLE;
                PAYLOAD: if (pay_idx == pay_len - 3'd1) p_next = CHECK;
                CHECK:   p_next = IDLE;
                default: p_next = IDLE;
            endcase
        end
    end

    always_comb begin
        report_now = byte_valid && (p_state == CHECK) && chk_ok;
        err_now    = (stop_err && (p_state != IDLE))
                   || tmo_hit
                   || (byte_valid && (p_state == TYPE)  && !type_ok)
                   || (byte_valid && (p_state == CHECK) && !chk_ok);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ftype   <= '0;
            pay_len <= '0;
            pay_idx <= '0;
            chk     <= '0;
            shadow  <= '0;
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= (p_state == IDLE || byte_valid) ? '0 : tmo_cnt + 1'b1;
            if (byte_valid) begin
                case (p_state)
                    TYPE: if (type_ok) begin
                        ftype   <= rx_shift[1:0];
                        chk     <= rx_shift;
                        pay_idx <= '0;
                        case (rx_shift[1:0])
                            2'd1:    pay_len <= 3'd5;
                            2'd2:    pay_len <= 3'd3;
                            default: pay_len <= 3'd2;
                        endcase
                    end
                    PAYLOAD: begin
                        shadow[pay_idx] <= rx_shift;
                        chk             <= chk ^ rx_shift;
                        pay_idx         <= pay_idx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- report outputs ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            usb_type      <= '0;
            usb_report    <= 1'b0;
            frame_err     <= 1'b0;
            key_modifiers <= '0;
            key1          <= '0;
            key2          <= '0;
            key3          <= '0;
            key4          <= '0;
            mouse_btn     <= '0;
            mouse_dx      <= '0;
            mouse_dy      <= '0;
            {game_l, game_r, game_u, game_d, game_a, game_b, game_x, game_y} <= '0;
            game_sel      <= 1'b0;
            game_sta      <= 1'b0;
        end else begin
            usb_report <= report_now;
            frame_err  <= err_now;
            if (report_now) begin
                usb_type <= ftype;
                case (ftype)
                    2'd1: begin
                        key_modifiers <= shadow[0];
                        key1          <= shadow[1];
                        key2          <= shadow[2];
                        key3          <= shadow[3];
                        key4          <= shadow[4];
                    end
                    2'd2: begin
                        mouse_btn <= shadow[0];
                        mouse_dx  <= $signed(shadow[1]);
                        mouse_dy  <= $signed(shadow[2]);
                    end
                    2'd3: begin
                        {game_l, game_r, game_u, game_d, game_a, game_b, game_x, game_y} <= shadow[0];
                        game_sel <= shadow[1][1];
                        game_sta <= shadow[1][0];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_hid_injector.sv
// Testbench for uart_hid_injector: directed frames over a serial driver,
// expected reports queued at send time and compared when usb_report fires.
module tb_uart_hid_injector;

    localparam int CPB = 64;     // clocks per UART bit in this bench
    localparam int TMO = 3000;   // inter-byte timeout in this bench
    localparam int W   = 76;     // width of the flattened report vector

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic uart_rx = 1'b1;

    always #5 clk = ~clk;

    logic [1:0]        usb_type;
    logic              usb_report, frame_err;
    logic [7:0]        key_modifiers, key1, key2, key3, key4, mouse_btn;
    logic signed [7:0] mouse_dx, mouse_dy;
    logic              game_l, game_r, game_u, game_d, game_a, game_b;
    logic              game_x, game_y, game_sel, game_sta;

    uart_hid_injector #(
        .CLK_FREQ      (6400000),
        .BAUD          (100000),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .uart_rx      (uart_rx),
        .usb_type     (usb_type),
        .usb_report   (usb_report),
        .key_modifiers(key_modifiers),
        .key1         (key1),
        .key2         (key2),
        .key3         (key3),
        .key4         (key4),
        .mouse_btn    (mouse_btn),
        .mouse_dx     (mouse_dx),
        .mouse_dy     (mouse_dy),
        .game_l       (game_l),
        .game_r       (game_r),
        .game_u       (game_u),
        .game_d       (game_d),
        .game_a       (game_a),
        .game_b       (game_b),
        .game_x       (game_x),
        .game_y       (game_y),
        .game_sel     (game_sel),
        .game_sta     (game_sta),
        .frame_err    (frame_err)
    );

    logic [W-1:0] dut_vec;
    assign dut_vec = {usb_type, key_modifiers, key1, key2, key3, key4,
                      mouse_btn, mouse_dx, mouse_dy,
                      game_l, game_r, game_u, game_d, game_a, game_b,
                      game_x, game_y, game_sel, game_sta};

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;
    int rep_cnt = 0;
    int err_cnt = 0;
    int rep0 = 0;
    int err0 = 0;
    logic prev_rep = 1'b0;
    logic prev_err = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   fr[$];

    // Reference copy of every output field.
    logic [1:0] m_type = '0;
    logic [7:0] m_mod = '0, m_k1 = '0, m_k2 = '0, m_k3 = '0, m_k4 = '0;
    logic [7:0] m_btn = '0, m_dx = '0, m_dy = '0;
    logic [9:0] m_game = '0;   // {l,r,u,d,a,b,x,y,sel,sta}

    function automatic logic [W-1:0] model_vec();
        return {m_type, m_mod, m_k1, m_k2, m_k3, m_k4, m_btn, m_dx, m_dy, m_game};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_kbd(input logic [7:0] mods, k1, k2, k3, k4);
        m_type = 2'd1; m_mod = mods; m_k1 = k1; m_k2 = k2; m_k3 = k3; m_k4 = k4;
        exp_q.push_back(model_vec());
    endtask

    task automatic expect_mouse(input logic [7:0] btn, dx, dy);
        m_type = 2'd2; m_btn = btn; m_dx = dx; m_dy = dy;
        exp_q.push_back(model_vec());
    endtask

    task automatic expect_game(input logic [9:0] g);
        m_type = 2'd3; m_game = g;
        exp_q.push_back(model_vec());
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (resetn) begin
            if (usb_report) begin
                rep_cnt++;
                check("report_excl_err", W'(frame_err), W'(0));
                check("report_one_cycle", W'(prev_rep), W'(0));
                check("report_expected", W'(exp_q.size() != 0), W'(1));
                if (exp_q.size() != 0) check("report_fields", dut_vec, exp_q.pop_front());
            end
            if (frame_err) begin
                err_cnt++;
                check("err_one_cycle", W'(prev_err), W'(0));
            end
        end
        prev_rep = usb_report;
        prev_err = frame_err;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = stop;
        tick(CPB);
        uart_rx = 1'b1;
        if (!stop) tick(CPB);   // give the line a high period before the next start
    endtask

    task automatic send_frame();
        foreach (fr[i]) send_byte(fr[i], 1'b1);
    endtask

    task automatic begin_step();
        rep0 = rep_cnt;
        err0 = err_cnt;
    endtask

    task automatic end_step(input string name, input int reps, input int errs);
        tick(20);
        check({name, "_reports"}, W'(rep_cnt - rep0), W'(reps));
        check({name, "_errors"}, W'(err_cnt - err0), W'(errs));
        check({name, "_fields"}, dut_vec, model_vec());
        check({name, "_drained"}, W'(exp_q.size()), W'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        tick(5);
        check("reset_fields", dut_vec, W'(0));
        check("reset_report", W'(usb_report), W'(0));
        check("reset_err", W'(frame_err), W'(0));
        resetn = 1'b1;
        tick(5);

        // Keyboard
        begin_step();
        expect_kbd(8'h02, 8'h04, 8'h00, 8'h00, 8'h00);
        fr = '{8'hA5, 8'h01, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h07};
        send_frame();
        end_step("kbd", 1, 0);

        // Mouse; keyboard fields must hold
        begin_step();
        expect_mouse(8'h01, 8'h05, 8'hFB);
        fr = '{8'hA5, 8'h02, 8'h01, 8'h05, 8'hFB, 8'hFD};
        send_frame();
        end_step("mouse", 1, 0);

        // Gamepad
        begin_step();
        expect_game(10'b1000_1000_01);
        fr = '{8'hA5, 8'h03, 8'h88, 8'h01, 8'h8A};
        send_frame();
        end_step("game", 1, 0);

        // Gamepad with bad checksum
        begin_step();
        fr = '{8'hA5, 8'h03, 8'h88, 8'h01, 8'h8B};
        send_frame();
        end_step("game_badchk", 0, 1);

        // Bad type
        begin_step();
        fr = '{8'hA5, 8'h07};
        send_frame();
        end_step("bad_type", 0, 1);

        // Junk then a valid mouse frame
        begin_step();
        expect_mouse(8'h03, 8'h10, 8'hF0);
        fr = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h03, 8'h10, 8'hF0, 8'hE1};
        send_frame();
        end_step("junk_mouse", 1, 0);

        // Framing error on the dx byte; trailing bytes are ignored in IDLE
        begin_step();
        fr = '{8'hA5, 8'h02, 8'h01};
        send_frame();
        send_byte(8'h05, 1'b0);
        fr = '{8'hFB, 8'hFD};
        send_frame();
        end_step("stop_bit", 0, 1);

        // Timeout mid-frame, then a valid keyboard frame
        begin_step();
        fr = '{8'hA5, 8'h01, 8'h02};
        send_frame();
        tick(TMO - 300);
        check("timeout_not_early", W'(err_cnt - err0), W'(0));
        tick(600);
        end_step("timeout", 0, 1);
        begin_step();
        expect_kbd(8'h02, 8'h04, 8'h00, 8'h00, 8'h00);
        fr = '{8'hA5, 8'h01, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h07};
        send_frame();
        end_step("after_timeout", 1, 0);

        // Back-to-back keyboard + mouse (dx at -128, dy at +127)
        begin_step();
        expect_kbd(8'h01, 8'h2C, 8'h00, 8'h00, 8'h00);
        expect_mouse(8'h00, 8'h80, 8'h7F);
        fr = '{8'hA5, 8'h01, 8'h01, 8'h2C, 8'h00, 8'h00, 8'h00, 8'h2C,
               8'hA5, 8'h02, 8'h00, 8'h80, 8'h7F, 8'hFD};
        send_frame();
        end_step("back_to_back", 2, 0);

        // Reset mid-payload
        fr = '{8'hA5, 8'h01, 8'h02};
        send_frame();
        tick(5);
        resetn = 1'b0;
        #1;
        check("mid_reset_fields", dut_vec, W'(0));
        m_type = '0; m_mod = '0; m_k1 = '0; m_k2 = '0; m_k3 = '0; m_k4 = '0;
        m_btn = '0; m_dx = '0; m_dy = '0; m_game = '0;
        tick(3);
        resetn = 1'b1;
        tick(5);
        begin_step();
        expect_kbd(8'h00, 8'h1E, 8'h1F, 8'h20, 8'h21);
        fr = '{8'hA5, 8'h01, 8'h00, 8'h1E, 8'h1F, 8'h20, 8'h21, 8'h01};
        send_frame();
        end_step("after_reset", 1, 0);

        // 20-clock glitch inside a frame must not produce a byte
        begin_step();
        expect_kbd(8'h02, 8'h04, 8'h00, 8'h00, 8'h00);
        fr = '{8'hA5};
        send_frame();
        tick(10);
        uart_rx = 1'b0;
        tick(20);
        uart_rx = 1'b1;
        tick(3 * CPB);
        fr = '{8'h01, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h07};
        send_frame();
        end_step("glitch", 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
